// File: rtl/video_wr_ctrl.sv
// Write-side VDMA front end: packs a pixel stream into AXI words, slices frames into bursts
// and rotates through a ring of frame buffers. Optional macro: VID_WR_TEST_PATTERN_EN.
module video_wr_ctrl #(
    parameter int          AXI_DATA_WIDTH = 128,
    parameter int          AXI_ADDR_WIDTH = 32,
    parameter int          PIX_WIDTH      = 32,
    parameter int          H_ACTIVE       = 1920,
    parameter int          V_ACTIVE       = 1080,
    parameter int          BURST_LEN      = 64,
    parameter logic [31:0] FRAME_BASE     = 32'h1000_0000,
    parameter logic [31:0] FRAME_STRIDE   = 32'h0080_0000,
    parameter int          FRAME_NUM      = 3
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
`ifdef VID_WR_TEST_PATTERN_EN
    input  logic                      i_test_en,
`endif
    input  logic                      i_vid_vs,
    input  logic                      i_vid_de,
    input  logic [PIX_WIDTH-1:0]      i_vid_data,
    output logic                      o_wr_buff_req_en,
    output logic [7:0]                o_wr_buff_burst_len,
    output logic [AXI_ADDR_WIDTH-1:0] o_wr_buff_addr,
    output logic                      o_wr_buff_vld,
    output logic [AXI_DATA_WIDTH-1:0] o_wr_buff_data,
    output logic                      o_wr_buff_data_last,
    output logic                      o_frame_done,
    output logic [2:0]                o_frame_idx,
    output logic                      o_pix_drop_err
);

    localparam int PPW         = AXI_DATA_WIDTH / PIX_WIDTH;
    localparam int FRAME_WORDS = (H_ACTIVE * V_ACTIVE) / PPW;
    localparam int WC_W        = $clog2(FRAME_WORDS + 1);
    localparam int PC_W        = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int BYTES       = AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE,
        S_PAD
    } state_t;

    state_t                    state;
    logic                      vs_d;
    logic [PC_W-1:0]           pix_cnt;
    logic [WC_W-1:0]           word_cnt;
    logic [7:0]                beat_cnt;
    logic [7:0]                cur_len;
    logic [2:0]                wr_idx;
    logic [AXI_DATA_WIDTH-1:0] pack_buf;

    logic                      vs_rise;
    logic                      pix_take;
    logic                      word_done;
    logic                      last_word;
    logic                      beat_last;
    logic [PIX_WIDTH-1:0]      pix;
    logic [AXI_DATA_WIDTH-1:0] word_full;
    logic [AXI_DATA_WIDTH-1:0] word_pad;
    logic [AXI_ADDR_WIDTH-1:0] burst_addr;
    logic [7:0]                burst_len_c;
    logic [31:0]               words_left;

    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx == 3'(FRAME_NUM - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

    assign vs_rise   = i_vid_vs & ~vs_d;
    assign pix_take  = (state == S_ACTIVE) && i_vid_de;
    assign word_done = pix_take && (pix_cnt == PC_W'(PPW - 1));
    assign last_word = (word_cnt == WC_W'(FRAME_WORDS - 1));

`ifdef VID_WR_TEST_PATTERN_EN
    logic                 test_mode;
    logic [PIX_WIDTH-1:0] pat_cnt;

    assign pix = test_mode ? pat_cnt : i_vid_data;

    // Pattern mode and counter are latched at the frame-start edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            test_mode <= 1'b0;
            pat_cnt   <= '0;
        end else if (vs_rise) begin
            test_mode <= i_test_en;
            pat_cnt   <= '0;
        end else if (pix_take) begin
            pat_cnt   <= pat_cnt + PIX_WIDTH'(1);
        end
    end
`else
    assign pix = i_vid_data;
`endif

    always_comb begin
        word_full = '0;
        word_pad  = '0;
        for (int i = 0; i < PPW; i++) begin
            word_full[i*PIX_WIDTH +: PIX_WIDTH] = (PC_W'(i) == pix_cnt) ? pix
                                                : pack_buf[i*PIX_WIDTH +: PIX_WIDTH];
            word_pad[i*PIX_WIDTH +: PIX_WIDTH]  = (PC_W'(i) < pix_cnt)
                                                ? pack_buf[i*PIX_WIDTH +: PIX_WIDTH]
                                                : '0;
        end
    end

    always_comb begin
        words_left  = 32'(FRAME_WORDS) - 32'(word_cnt);
        burst_len_c = (words_left >= 32'(BURST_LEN)) ? 8'(BURST_LEN - 1)
                                                     : 8'(words_left - 32'd1);
        burst_addr  = AXI_ADDR_WIDTH'(FRAME_BASE)
                    + AXI_ADDR_WIDTH'(wr_idx) * AXI_ADDR_WIDTH'(FRAME_STRIDE)
                    + AXI_ADDR_WIDTH'(word_cnt) * AXI_ADDR_WIDTH'(BYTES);
        beat_last   = (beat_cnt == 8'd0) ? (burst_len_c == 8'd0) : (beat_cnt == cur_len);
    end

    // Pixel packing register: pure data, no reset needed since slices above pix_cnt are masked.
    always_ff @(posedge i_clk) begin
        if (pix_take) begin
            pack_buf[pix_cnt*PIX_WIDTH +: PIX_WIDTH] <= pix;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state               <= S_IDLE;
            vs_d                <= 1'b0;
            pix_cnt             <= '0;
            word_cnt            <= '0;
            beat_cnt            <= '0;
            cur_len             <= '0;
            wr_idx              <= '0;
            o_wr_buff_req_en    <= 1'b0;
            o_wr_buff_burst_len <= '0;
            o_wr_buff_addr      <= '0;
            o_wr_buff_vld       <= 1'b0;
            o_wr_buff_data      <= '0;
            o_wr_buff_data_last <= 1'b0;
            o_frame_done        <= 1'b0;
            o_frame_idx         <= '0;
            o_pix_drop_err      <= 1'b0;
        end else begin
            vs_d                <= i_vid_vs;
            o_wr_buff_req_en    <= 1'b0;
            o_wr_buff_vld       <= 1'b0;
            o_wr_buff_data_last <= 1'b0;
            o_frame_done        <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (vs_rise) begin
                        state    <= S_ACTIVE;
                        pix_cnt  <= '0;
                        word_cnt <= '0;
                        beat_cnt <= '0;
                    end
                end

                S_ACTIVE: begin
                    if (pix_take) begin
                        pix_cnt <= word_done ? '0 : pix_cnt + PC_W'(1);
                    end
                    if (word_done) begin
                        o_wr_buff_vld       <= 1'b1;
                        o_wr_buff_data      <= word_full;
                        o_wr_buff_data_last <= beat_last;
                        word_cnt            <= word_cnt + WC_W'(1);
                        beat_cnt            <= beat_last ? 8'd0 : beat_cnt + 8'd1;
                        if (beat_cnt == 8'd0) begin
                            o_wr_buff_req_en    <= 1'b1;
                            o_wr_buff_addr      <= burst_addr;
                            o_wr_buff_burst_len <= burst_len_c;
                            cur_len             <= burst_len_c;
                        end
                        if (last_word) begin
                            // A vs edge on the final pixel starts the next frame directly.
                            o_frame_done <= 1'b1;
                            o_frame_idx  <= wr_idx;
                            wr_idx       <= next_idx(wr_idx);
                            word_cnt     <= '0;
                            beat_cnt     <= '0;
                            state        <= vs_rise ? S_ACTIVE : S_DONE;
                        end else if (vs_rise) begin
                            state <= S_PAD;
                        end
                    end else if (vs_rise) begin
                        state <= S_PAD;
                    end
                end

                S_DONE: begin
                    if (i_vid_de) begin
                        o_pix_drop_err <= 1'b1;
                    end
                    if (vs_rise) begin
                        state    <= S_ACTIVE;
                        pix_cnt  <= '0;
                        word_cnt <= '0;
                        beat_cnt <= '0;
                    end
                end

                S_PAD: begin
                    if (i_vid_de) begin
                        o_pix_drop_err <= 1'b1;
                    end
                    // Only an already-open burst is closed out; a partial word with no open
                    // burst has no command to ride on and is discarded.
                    if (beat_cnt != 8'd0) begin
                        o_wr_buff_vld       <= 1'b1;
                        o_wr_buff_data      <= (pix_cnt != '0) ? word_pad : '0;
                        o_wr_buff_data_last <= (beat_cnt == cur_len);
                        pix_cnt             <= '0;
                        word_cnt            <= word_cnt + WC_W'(1);
                        beat_cnt            <= (beat_cnt == cur_len) ? 8'd0 : beat_cnt + 8'd1;
                        if (beat_cnt == cur_len) begin
                            o_frame_done <= 1'b1;
                            o_frame_idx  <= wr_idx;
                            wr_idx       <= next_idx(wr_idx);
                            word_cnt     <= '0;
                            state        <= S_ACTIVE;
                        end
                    end else begin
                        o_frame_done <= 1'b1;
                        o_frame_idx  <= wr_idx;
                        wr_idx       <= next_idx(wr_idx);
                        pix_cnt      <= '0;
                        word_cnt     <= '0;
                        state        <= S_ACTIVE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/video_wr_ctrl.md
Name: video_wr_ctrl

Overview:
- Write-side front end of the VDMA. Accepts a single-clock video pixel stream and packs pixels into AXI_DATA_WIDTH words.
- Slices each frame into AXI bursts and drives the command/data interface of the write buffer stage directly downstream.
- Writes frames into a ring of FRAME_NUM buffers in DDR and reports each completed frame index to the read side.

Parameters:
- AXI_DATA_WIDTH, 128, packed word width; one of 64/128/256.
- AXI_ADDR_WIDTH, 32, address width.
- PIX_WIDTH, 32, pixel width; must divide AXI_DATA_WIDTH. PPW = AXI_DATA_WIDTH/PIX_WIDTH.
- H_ACTIVE, 1920, active pixels per line.
- V_ACTIVE, 1080, active lines per frame. H_ACTIVE*V_ACTIVE must be a multiple of PPW. FRAME_WORDS = H_ACTIVE*V_ACTIVE/PPW.
- BURST_LEN, 64, beats per full burst; 1..256. BURST_LEN*AXI_DATA_WIDTH/8 must be ≤4096.
- FRAME_BASE, 32'h1000_0000, address of frame 0. Must be aligned to the burst byte size.
- FRAME_STRIDE, 32'h0080_0000, byte distance between frames. Must be 4 KB aligned.
- FRAME_NUM, 3, ring depth; 1..8.

Ports:
- i_clk  in  1  pixel/system clock.
- i_reset_n  in  1  reset; asynchronous assert, active-low.
- i_vid_vs  in  1  frame start; the rising edge is the event.
- i_vid_de  in  1  pixel valid.
- i_vid_data  in  PIX_WIDTH  pixel.
- o_wr_buff_req_en  out  1  burst command pulse.
- o_wr_buff_burst_len  out  8  beats-1 of the burst.
- o_wr_buff_addr  out  AXI_ADDR_WIDTH  burst start byte address.
- o_wr_buff_vld  out  1  data beat valid.
- o_wr_buff_data  out  AXI_DATA_WIDTH  packed word.
- o_wr_buff_data_last  out  1  last beat of the burst.
- o_frame_done  out  1  one-cycle pulse when a frame's final beat is issued.
- o_frame_idx  out  3  index of the most recently completed frame.
- o_pix_drop_err  out  1  sticky; pixels were discarded.

Behaviour:
- Reset: all outputs are 0; state is IDLE; write frame index = 0; all counters = 0.
- All outputs are registered. There is no backpressure: the downstream stage always accepts.

State machine:
- IDLE → ACTIVE on the first vs rising edge. de is ignored in IDLE.
- ACTIVE: packs pixels. The first pixel goes to bits [PIX_WIDTH-1:0], the next pixel to the next-higher slice.
- When the PPW-th pixel arrives, the word is emitted next cycle: o_wr_buff_vld=1 and word_cnt increments.
- At beat 0 of each burst, o_wr_buff_req_en=1 in the same cycle as that vld, with:
  - addr = FRAME_BASE + wr_idx*FRAME_STRIDE + word_cnt*(AXI_DATA_WIDTH/8)
  - len = min(BURST_LEN, FRAME_WORDS-word_cnt) - 1
- data_last=1 on the beat where beat_cnt == len.
- When word_cnt reaches FRAME_WORDS:
  - o_frame_done pulses with the last beat.
  - o_frame_idx ← wr_idx.
  - wr_idx advances: (wr_idx+1) mod FRAME_NUM.
  - State → DONE.
- DONE: de pixels are dropped and set o_pix_drop_err. The next vs edge resets the counters → ACTIVE.
- vs edge while ACTIVE with word_cnt < FRAME_WORDS (short frame) → PAD.
- PAD:
  - If a partial word is held, it is completed with zero pixels.
  - Zero beats are then emitted one per cycle until the open burst closes (data_last).
  - No new bursts are issued.
  - Then frame_done/idx update as normal, and the state goes to ACTIVE for the new frame with counters cleared.
  - de during PAD is dropped and sets o_pix_drop_err.
  - If no burst is open and no partial word is held, PAD lasts 0 beats; it takes one cycle.
- vs edge in the same cycle as the frame's final pixel: the frame completes normally and the new frame starts, with no PAD.
- Reset mid-burst: outputs clear immediately. Upstream resets the write buffer together with this block.
- o_pix_drop_err clears only on reset.

Optional Feature:
- Macro: VID_WR_TEST_PATTERN_EN.
- Defined:
  - Adds input i_test_en (1 bit).
  - When i_test_en=1, each accepted pixel's value is replaced by a PIX_WIDTH counter. The counter resets to 0 at each frame start and increments per accepted pixel.
  - i_test_en is sampled only at the vs edge.
- Undefined: the port is absent and pixel data passes through unchanged.

Test Plan:
- Nominal frame (PIX 32, AXI 128, H=20, V=3, BURST_LEN=8, base 0x1000_0000): 60 pixels with de held high.
  - Required: two req_en.
  - Burst 1: addr 0x1000_0000, len 7.
  - Burst 2: addr 0x1000_0080, len 6.
  - 15 vld beats; data_last on beats 8 and 15; frame_done once; o_frame_idx=0.
- Packing: pixels 0x0,0x1,0x2,0x3 → first word 0x00000003_00000002_00000001_00000000.
- Ring wrap (FRAME_NUM=3): 4 full frames.
  - Burst-0 addresses: 0x1000_0000, 0x1080_0000, 0x1100_0000, 0x1000_0000.
  - o_frame_idx sequence: 0, 1, 2, 0.
- Short frame: vs edge after 22 pixels.
  - Word 6 is padded (pixels 22,23 = 0).
  - Beats 7,8 are zero; data_last on beat 8.
  - No req_en for a second burst; frame_done pulses.
- Excess pixels: 8 extra de cycles after frame end → no vld, and o_pix_drop_err=1 until reset.
- Async reset asserted mid-burst: all outputs are 0 within the same cycle. After release, de without a vs edge produces no output.
